// File: rtl/ddr_access_arbiter.sv
// Arbitrates display reads, draw writes and auto-refresh onto one DDR command port.
// Optional refresh generator: define DDR_ARB_REFRESH_EN.
module ddr_access_arbiter #(
  parameter int REFRESH_INTERVAL = 1037,
  parameter int REFRESH_MAX      = 8,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic        clk133,
  input  logic        rst_n,
  input  logic        initDone,
  input  logic        dispReq,
  input  logic [24:0] dispAddr,
  output logic        dispAck,
  input  logic        drawReq,
  input  logic [24:0] drawAddr,
  output logic        drawAck,
  output logic        cmdValid,
  input  logic        cmdReady,
  output logic [1:0]  cmdOp,
  output logic [1:0]  cmdBank,
  output logic [12:0] cmdRow,
  output logic [9:0]  cmdCol,
  input  logic        ctlDone,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_REF = 2'b10;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int PW = $clog2(REFRESH_MAX + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_MAX);

  state_t state, state_nx;

  logic [1:0]    op_q;
  logic [24:0]   addr_q;
  logic [SW-1:0] starve;
  logic [PW-1:0] refPend;

  logic          idle_ok;
  logic          ref_el;
  logic          draw_force;
  logic          g_ref, g_d, g_draw, grant;
  logic [1:0]    sel_op;
  logic [24:0]   sel_addr;
  logic          accept;

  assign idle_ok    = (state == IDLE) && initDone;
  assign ref_el     = (refPend != '0);
  assign draw_force = drawReq && (starve == SLIM);

  // One-hot priority terms so the decoder below is truly unique
  assign g_ref  = idle_ok && ref_el;
  assign g_draw = idle_ok && !ref_el &&
                  (draw_force || (!dispReq && drawReq));
  assign g_d    = idle_ok && !ref_el && !draw_force && dispReq;
  assign grant  = g_ref || g_d || g_draw;

  always_comb begin
    sel_op   = OP_RD;
    sel_addr = '0;
    unique case (1'b1)
      g_ref: begin
        sel_op = OP_REF;
      end
      g_d: begin
        sel_op   = OP_RD;
        sel_addr = dispAddr;
      end
      g_draw: begin
        sel_op   = OP_WR;
        sel_addr = drawAddr;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant)    state_nx = ISSUE;
      ISSUE:   if (cmdReady) state_nx = WAIT;
      WAIT:    if (ctlDone)  state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk133 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk133 or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      addr_q <= '0;
    end else if (grant) begin
      op_q   <= sel_op;
      addr_q <= sel_addr;
    end
  end

  always_ff @(posedge clk133 or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (g_draw) begin
      starve <= '0;
    end else if (g_d && drawReq && starve != SLIM) begin
      starve <= starve + 1'b1;
    end
  end

  assign accept   = (state == ISSUE) && cmdReady;
  assign cmdValid = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign dispAck  = accept && (op_q == OP_RD);
  assign drawAck  = accept && (op_q == OP_WR);
  assign cmdOp    = op_q;
  assign cmdBank  = addr_q[24:23];
  assign cmdRow   = addr_q[22:10];
  assign cmdCol   = addr_q[9:0];

`ifdef DDR_ARB_REFRESH_EN
  localparam int RCW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [RCW-1:0] RELOAD = RCW'(REFRESH_INTERVAL - 1);

  logic [RCW-1:0] refCnt;
  logic           ref_tick;
  logic           ref_take;

  assign ref_tick = initDone && (refCnt == '0);
  assign ref_take = accept && (op_q == OP_REF);

  always_ff @(posedge clk133 or negedge rst_n) begin
    if (!rst_n)        refCnt <= RELOAD;
    else if (!initDone) refCnt <= RELOAD;
    else if (ref_tick) refCnt <= RELOAD;
    else               refCnt <= refCnt - 1'b1;
  end

  // A tick and an accept in the same cycle cancel out
  always_ff @(posedge clk133 or negedge rst_n) begin
    if (!rst_n) begin
      refPend <= '0;
    end else if (ref_tick && !ref_take) begin
      if (refPend != PMAX) refPend <= refPend + 1'b1;
    end else if (ref_take && !ref_tick) begin
      refPend <= refPend - 1'b1;
    end
  end
`else
  logic unused_ref;
  assign refPend    = '0;
  assign unused_ref = ^{32'(REFRESH_INTERVAL), PMAX, OP_REF};
`endif

endmodule

// File: tb/tb_ddr_access_arbiter.sv
// Directed-vector bench for ddr_access_arbiter.
// Refresh scenario runs only when DDR_ARB_REFRESH_EN is defined.
module tb_ddr_access_arbiter;

`ifdef DDR_ARB_REFRESH_EN
  localparam int RI = 16;
`else
  localparam int RI = 1037;
`endif

  logic        clk133 = 1'b0;
  logic        rst_n;
  logic        initDone;
  logic        dispReq;
  logic [24:0] dispAddr;
  logic        dispAck;
  logic        drawReq;
  logic [24:0] drawAddr;
  logic        drawAck;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [1:0]  cmdBank;
  logic [12:0] cmdRow;
  logic [9:0]  cmdCol;
  logic        ctlDone;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  ddr_access_arbiter #(
    .REFRESH_INTERVAL(RI),
    .REFRESH_MAX(8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk133(clk133),
    .rst_n(rst_n),
    .initDone(initDone),
    .dispReq(dispReq),
    .dispAddr(dispAddr),
    .dispAck(dispAck),
    .drawReq(drawReq),
    .drawAddr(drawAddr),
    .drawAck(drawAck),
    .cmdValid(cmdValid),
    .cmdReady(cmdReady),
    .cmdOp(cmdOp),
    .cmdBank(cmdBank),
    .cmdRow(cmdRow),
    .cmdCol(cmdCol),
    .ctlDone(ctlDone),
    .busy(busy)
  );

  always #5 clk133 = ~clk133;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    initDone = 1'b0;
    dispReq  = 1'b0;
    dispAddr = '0;
    drawReq  = 1'b0;
    drawAddr = '0;
    cmdReady = 1'b0;
    ctlDone  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk133);
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk133);
    rst_n = 1'b1;
    @(negedge clk133);
  endtask

  task automatic serve(input int lat,
                       output logic [1:0] op,
                       output logic da,
                       output logic wa);
    int t = 0;
    while (!cmdValid && t < 200) begin
      @(negedge clk133);
      t++;
    end
    check("serve_valid", 32'(cmdValid), 32'd1);
    op = cmdOp;
    da = dispAck;
    wa = drawAck;
    repeat (lat) @(negedge clk133);
    ctlDone = 1'b1;
    @(negedge clk133);
    ctlDone = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int bad;
    int acks;
    int n;
    int guard;
    logic [1:0]  op;
    logic        da, wa;
    logic [1:0]  op0;
    logic [24:0] f0;
    logic [1:0]  exp_gr [10];

    exp_gr = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
               2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    // reset values
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk133);
    #1;
    check("rst_valid", 32'(cmdValid), 32'd0);
    check("rst_dack",  32'(dispAck),  32'd0);
    check("rst_wack",  32'(drawAck),  32'd0);
    check("rst_op",    32'(cmdOp),    32'd0);
    check("rst_bank",  32'(cmdBank),  32'd0);
    check("rst_row",   32'(cmdRow),   32'd0);
    check("rst_col",   32'(cmdCol),   32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    @(negedge clk133);
    rst_n = 1'b1;

    // request held while init is incomplete
    dispAddr = 25'h1ABCDEF;
    dispReq  = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk133);
      if (cmdValid) cnt++;
    end
    check("preinit_valid", 32'(cnt), 32'd0);
    initDone = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk133);
      if (cmdValid) break;
    end
    check("init_valid", 32'(cmdValid), 32'd1);
    check("init_op",    32'(cmdOp),    32'd0);

    // address split and ack pulse
    check("disp_bank", 32'(cmdBank), 32'd3);
    check("disp_row",  32'(cmdRow),  32'h0AF3);
    check("disp_col",  32'(cmdCol),  32'h1EF);
    check("dack_nrdy", 32'(dispAck), 32'd0);
    cmdReady = 1'b1;
    #1;
    check("dack_on",  32'(dispAck), 32'd1);
    check("wack_off", 32'(drawAck), 32'd0);
    @(negedge clk133);
    check("dack_pulse",  32'(dispAck),  32'd0);
    check("wait_valid",  32'(cmdValid), 32'd0);
    check("wait_busy",   32'(busy),     32'd1);
    dispReq  = 1'b0;
    drawReq  = 1'b1;
    drawAddr = 25'h0000123;
    cnt = 0;
    repeat (5) begin
      @(negedge clk133);
      if (cmdValid) cnt++;
    end
    check("wait_hold", 32'(cnt), 32'd0);
    ctlDone = 1'b1;
    @(negedge clk133);
    ctlDone = 1'b0;
    check("idle_gap", 32'(cmdValid), 32'd0);
    @(negedge clk133);
    check("draw_valid", 32'(cmdValid), 32'd1);
    check("draw_op",    32'(cmdOp),    32'd1);
    check("draw_ack",   32'(drawAck),  32'd1);
    check("draw_col",   32'(cmdCol),   32'h123);

    // cmdReady stall with competing request changes
    do_reset();
    drawAddr = 25'h0F0F0F5;
    drawReq  = 1'b1;
    initDone = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk133);
      if (cmdValid) break;
    end
    check("stall_valid", 32'(cmdValid), 32'd1);
    op0 = cmdOp;
    f0  = {cmdBank, cmdRow, cmdCol};
    dispReq  = 1'b1;
    dispAddr = 25'h1555555;
    bad  = 0;
    acks = 0;
    repeat (10) begin
      @(negedge clk133);
      if (!cmdValid || cmdOp != op0 ||
          {cmdBank, cmdRow, cmdCol} != f0) bad++;
      if (dispAck || drawAck) acks++;
    end
    check("stall_stable", 32'(bad),  32'd0);
    check("stall_noack",  32'(acks), 32'd0);
    check("stall_op",   32'(cmdOp),   32'd1);
    check("stall_bank", 32'(cmdBank), 32'd1);
    check("stall_row",  32'(cmdRow),  32'h1C3C);
    check("stall_col",  32'(cmdCol),  32'h0F5);
    cmdReady = 1'b1;
    #1;
    check("stall_wack", 32'(drawAck), 32'd1);
    check("stall_dack", 32'(dispAck), 32'd0);

    // reset while waiting for completion
    do_reset();
    dispAddr = 25'h0000ABC;
    dispReq  = 1'b1;
    initDone = 1'b1;
    cmdReady = 1'b1;
    @(negedge clk133);
    check("abort_ack", 32'(dispAck), 32'd1);
    @(negedge clk133);
    dispReq = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outs",
          32'({cmdValid, busy, dispAck, drawAck,
               cmdOp, cmdBank, cmdRow, cmdCol}),
          32'd0);
    @(negedge clk133);
    ctlDone = 1'b1;
    @(negedge clk133);
    ctlDone = 1'b0;
    rst_n   = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clk133);
      if (dispAck || drawAck) acks++;
    end
    check("abort_noack", 32'(acks), 32'd0);

    // starvation ordering
    do_reset();
    initDone = 1'b1;
    cmdReady = 1'b1;
    dispAddr = 25'h0000010;
    drawAddr = 25'h0000020;
    dispReq  = 1'b1;
    drawReq  = 1'b1;
    n = 0;
    guard = 0;
    while (n < 10 && guard < 40) begin
      serve(3, op, da, wa);
      guard++;
      if (op != 2'b10) begin
        check($sformatf("order_%0d", n), 32'({da, wa}), 32'(exp_gr[n]));
        n++;
      end
    end
    check("order_cnt", 32'(n), 32'd10);
    dispReq = 1'b0;
    drawReq = 1'b0;

`ifdef DDR_ARB_REFRESH_EN
    // refreshes accumulate during a long WAIT and win over display
    do_reset();
    dispAddr = 25'h0000040;
    dispReq  = 1'b1;
    initDone = 1'b1;
    cmdReady = 1'b1;
    serve(40, op, da, wa);
    check("ref_first_op", 32'(op), 32'd0);
    serve(1, op, da, wa);
    check("ref_op_1", 32'(op), 32'd2);
    check("ref_ack_1", 32'({da, wa}), 32'd0);
    serve(1, op, da, wa);
    check("ref_op_2", 32'(op), 32'd2);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      serve(1, op, da, wa);
      if (op == 2'b00 && da) begin
        cnt = 1;
        break;
      end
    end
    check("ref_disp_after", 32'(cnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
